// File: rtl/mips_pipe_pkg.sv
// rtl/mips_pipe_pkg.sv - shared pipeline types and constants for the hazard controller
package mips_pipe_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam int unsigned REG_ZERO   = 0;
  localparam logic [31:0] NOP_INSTR  = 32'h00000000;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } haz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - combinational load-use comparator between ID/EX load and IF/ID sources
module load_use_detect
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  output logic                  hazard
);

  // $zero never carries a real dependency, so a load targeting it cannot stall
  assign hazard = ex_mem_read
               && (ex_rt != REG_ADDR_W'(REG_ZERO))
               && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - PC/IF/ID/ID/EX stall, flush and freeze control; HAZ_STATS_EN adds stall/flush counters
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = mips_pipe_pkg::REG_ADDR_W,
  parameter int CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [REG_ADDR_W-1:0] ID_RS,
  input  logic [REG_ADDR_W-1:0] ID_RT,
  input  logic                  ID_USES_RT,
  input  logic                  EX_MEM_READ,
  input  logic [REG_ADDR_W-1:0] EX_RT,
  input  logic                  BRANCH_TAKEN,
  input  logic                  MEM_REQ,
  input  logic                  MEM_READY,
  output logic                  PC_WRITE,
  output logic                  IF_ID_WRITE,
  output logic                  IF_ID_FLUSH,
  output logic                  ID_EX_BUBBLE,
  output logic                  PIPE_FREEZE
`ifdef HAZ_STATS_EN
  ,
  output logic [CNT_W-1:0]      STALL_CNT,
  output logic [CNT_W-1:0]      FLUSH_CNT
`endif
);

  haz_state_t state, state_nxt;
  logic       hazard;
  logic       wait_now;

  load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use_detect (
    .id_rs       (ID_RS),
    .id_rt       (ID_RT),
    .id_uses_rt  (ID_USES_RT),
    .ex_mem_read (EX_MEM_READ),
    .ex_rt       (EX_RT),
    .hazard      (hazard)
  );

  // Once frozen, only MEM_READY releases; MEM_REQ is not re-sampled while waiting
  assign wait_now = (state == MEM_WAIT) ? !MEM_READY : (MEM_REQ && !MEM_READY);

  always_comb begin
    PC_WRITE     = 1'b1;
    IF_ID_WRITE  = 1'b1;
    IF_ID_FLUSH  = 1'b0;
    ID_EX_BUBBLE = 1'b0;
    PIPE_FREEZE  = 1'b0;
    state_nxt    = RUN;
    if (RST) begin
      PC_WRITE     = 1'b0;
      IF_ID_WRITE  = 1'b0;
      IF_ID_FLUSH  = 1'b1;
      ID_EX_BUBBLE = 1'b1;
    end else if (wait_now) begin
      PC_WRITE    = 1'b0;
      IF_ID_WRITE = 1'b0;
      PIPE_FREEZE = 1'b1;
      state_nxt   = MEM_WAIT;
    end else if (BRANCH_TAKEN) begin
      IF_ID_FLUSH  = 1'b1;
      ID_EX_BUBBLE = 1'b1;
    end else if (hazard && (state != LOAD_STALL)) begin
      PC_WRITE     = 1'b0;
      IF_ID_WRITE  = 1'b0;
      ID_EX_BUBBLE = 1'b1;
      state_nxt    = LOAD_STALL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= state_nxt;
  end

`ifdef HAZ_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (!PC_WRITE && (STALL_CNT != '1))   STALL_CNT <= STALL_CNT + CNT_W'(1);
      if (IF_ID_FLUSH && (FLUSH_CNT != '1)) FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
    end
  end
`else
  logic [CNT_W-1:0] stats_unused;
  assign stats_unused = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl (HAZ_STATS_EN optional)
module tb_pipe_hazard_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [4:0] ID_RS, ID_RT, EX_RT;
  logic       ID_USES_RT, EX_MEM_READ, BRANCH_TAKEN, MEM_REQ, MEM_READY;
  logic       PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE;
`ifdef HAZ_STATS_EN
  logic [15:0] STALL_CNT, FLUSH_CNT;
`endif

  int checks   = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  typedef struct {
    string      tag;
    logic [4:0] val;
    logic [4:0] mask;
    logic       rst;
  } exp_t;
  exp_t sb[$];

  // {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE}
  localparam logic [4:0] V_RST = 5'b00110;
  localparam logic [4:0] V_ADV = 5'b11000;
  localparam logic [4:0] V_LDS = 5'b00010;
  localparam logic [4:0] V_BR  = 5'b10110;
  localparam logic [4:0] V_FRZ = 5'b00001;
  localparam logic [4:0] M_ALL = 5'b11111;
  localparam logic [4:0] M_BR  = 5'b10111;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .ID_RS        (ID_RS),
    .ID_RT        (ID_RT),
    .ID_USES_RT   (ID_USES_RT),
    .EX_MEM_READ  (EX_MEM_READ),
    .EX_RT        (EX_RT),
    .BRANCH_TAKEN (BRANCH_TAKEN),
    .MEM_REQ      (MEM_REQ),
    .MEM_READY    (MEM_READY),
    .PC_WRITE     (PC_WRITE),
    .IF_ID_WRITE  (IF_ID_WRITE),
    .IF_ID_FLUSH  (IF_ID_FLUSH),
    .ID_EX_BUBBLE (ID_EX_BUBBLE),
    .PIPE_FREEZE  (PIPE_FREEZE)
`ifdef HAZ_STATS_EN
    ,
    .STALL_CNT    (STALL_CNT),
    .FLUSH_CNT    (FLUSH_CNT)
`endif
  );

  task automatic drive(input logic rst, input logic mrd, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic mreq, input logic mrdy);
    @(negedge CLK);
    RST = rst; EX_MEM_READ = mrd; EX_RT = ert; ID_RS = rs; ID_RT = rt;
    ID_USES_RT = urt; BRANCH_TAKEN = br; MEM_REQ = mreq; MEM_READY = mrdy;
  endtask

  // Push the expected control word for this cycle, then pop and compare before the edge
  task automatic expect_ctl(input string tag, input logic [4:0] val, input logic [4:0] mask);
    exp_t e, got;
    logic [4:0] obs;
    e.tag = tag; e.val = val; e.mask = mask; e.rst = RST;
    sb.push_back(e);
    #2;
    got = sb.pop_front();
    obs = {PC_WRITE, IF_ID_WRITE, IF_ID_FLUSH, ID_EX_BUBBLE, PIPE_FREEZE};
    checks++;
    assert ((obs & got.mask) === (got.val & got.mask))
    else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b (mask %b)", got.tag, obs, got.val, got.mask);
    end
    if (got.rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!got.val[4]) exp_stall++;
      if (got.val[2])  exp_flush++;
    end
  endtask

`ifdef HAZ_STATS_EN
  task automatic check_cnt(input string tag);
    checks++;
    assert (STALL_CNT === 16'(exp_stall))
    else begin
      failures++;
      $error("FAIL %s_stall: observed=%0d expected=%0d", tag, STALL_CNT, exp_stall);
    end
    checks++;
    assert (FLUSH_CNT === 16'(exp_flush))
    else begin
      failures++;
      $error("FAIL %s_flush: observed=%0d expected=%0d", tag, FLUSH_CNT, exp_flush);
    end
  endtask
`endif

  initial begin
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_ctl("reset0", V_RST, M_ALL);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); expect_ctl("reset1", V_RST, M_ALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_ctl("after_reset", V_ADV, M_ALL);
`ifdef HAZ_STATS_EN
    check_cnt("cnt_reset");
`endif

    drive(0, 1, 8, 8, 2, 0, 0, 0, 0); expect_ctl("lu_rs_stall", V_LDS, M_ALL);
    drive(0, 1, 8, 8, 2, 0, 0, 0, 0); expect_ctl("lu_rs_masked", V_ADV, M_ALL);
    drive(0, 1, 9, 3, 9, 1, 0, 0, 0); expect_ctl("lu_rt_stall", V_LDS, M_ALL);
    drive(0, 0, 9, 3, 9, 1, 0, 0, 0); expect_ctl("lu_rt_clear", V_ADV, M_ALL);

    drive(0, 1, 0, 0, 0, 1, 0, 0, 0); expect_ctl("no_haz_r0", V_ADV, M_ALL);
    drive(0, 1, 9, 3, 9, 0, 0, 0, 0); expect_ctl("no_haz_nort", V_ADV, M_ALL);

    drive(0, 1, 8, 8, 0, 0, 1, 0, 0); expect_ctl("br_over_lu", V_BR, M_BR);
    drive(0, 0, 8, 8, 0, 0, 0, 0, 0); expect_ctl("after_br", V_ADV, M_ALL);

    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8, 8, 0, 0, 1, 1, 0); expect_ctl($sformatf("mem_frz%0d", i), V_FRZ, M_ALL);
    end
    drive(0, 0, 0, 0, 0, 0, 1, 1, 1); expect_ctl("mem_release_br", V_BR, M_BR);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_ctl("mem_idle", V_ADV, M_ALL);
`ifdef HAZ_STATS_EN
    check_cnt("cnt_scen");
`endif

    drive(0, 0, 0, 0, 0, 0, 0, 1, 0); expect_ctl("wait_pre_rst", V_FRZ, M_ALL);
    drive(1, 0, 0, 0, 0, 0, 0, 1, 0); expect_ctl("rst_in_wait", V_RST, M_ALL);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); expect_ctl("wait_discarded", V_ADV, M_ALL);
`ifdef HAZ_STATS_EN
    check_cnt("cnt_after_rst");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
